// File: rtl/adder_tree_arbiter.sv
// Two-requester front end sharing one pipelined adder tree.
// Ports: clk, reset (async, active-high);
//   in0_/in1_valid, in0_/in1_ready, in0_/in1_addends: requester vectors;
//   out_valid, out_ready, out_sum, out_id: result stream.
// Optional macro ADDER_TREE_ARB_SKID_EN adds a 2-entry output FIFO.
// With the FIFO, advance comes from a flop, so out_ready does not reach
// the input ready signals combinationally.

module AdderTreePipelined #(
    parameter int DATA_WIDTH = 5,
    parameter int LENGTH     = 9
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_advance,
    input  logic [LENGTH-1:0][DATA_WIDTH-1:0]        in_addends,
    output logic signed [DATA_WIDTH+$clog2(LENGTH)-1:0] out_sum
);
    localparam int LATENCY   = $clog2(LENGTH);
    localparam int OUT_WIDTH = DATA_WIDTH + LATENCY;
    localparam int LEAVES    = 1 << LATENCY;

    // Leaves beyond LENGTH are zero so the tree is a full binary tree.
    logic [LEAVES-1:0][DATA_WIDTH-1:0] padded;
    assign padded = (LEAVES*DATA_WIDTH)'(in_addends);

    for (genvar l = 0; l <= LATENCY; l++) begin : g_lvl
        localparam int N = LEAVES >> l;
        logic signed [OUT_WIDTH-1:0] node [N];
        if (l == 0) begin : g_leaf
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    node[i] = OUT_WIDTH'($signed(padded[i]));
                end
            end
        end else begin : g_add
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < N; i++) begin
                        node[i] <= '0;
                    end
                end else if (in_advance) begin
                    for (int i = 0; i < N; i++) begin
                        node[i] <= g_lvl[l-1].node[2*i]
                                 + g_lvl[l-1].node[2*i+1];
                    end
                end
            end
        end
    end

    assign out_sum = g_lvl[LATENCY].node[0];
endmodule

module adder_tree_arbiter #(
    parameter  int DATA_WIDTH = 5,
    parameter  int LENGTH     = 9,
    localparam int LATENCY    = $clog2(LENGTH),
    localparam int OUT_WIDTH  = DATA_WIDTH + LATENCY
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in0_valid,
    output logic                              in0_ready,
    input  logic [LENGTH-1:0][DATA_WIDTH-1:0] in0_addends,
    input  logic                              in1_valid,
    output logic                              in1_ready,
    input  logic [LENGTH-1:0][DATA_WIDTH-1:0] in1_addends,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [OUT_WIDTH-1:0]       out_sum,
    output logic                              out_id
);
    logic                              advance;
    logic                              any_valid;
    logic                              both_valid;
    logic                              grant_id;
    logic                              accept;
    logic                              rr;
    logic [LENGTH-1:0][DATA_WIDTH-1:0] tree_in;
    logic signed [OUT_WIDTH-1:0]       tree_sum;
    logic [LATENCY-1:0]                tag_valid;
    logic [LATENCY-1:0]                tag_id;

    assign any_valid  = in0_valid | in1_valid;
    assign both_valid = in0_valid & in1_valid;
    // Sole requester wins; on contention the round-robin pointer decides.
    assign grant_id   = both_valid ? rr : in1_valid;
    assign accept     = advance & any_valid;
    assign in0_ready  = accept & ~grant_id;
    assign in1_ready  = accept & grant_id;
    assign tree_in    = !accept ? '0
                      : (grant_id ? in1_addends : in0_addends);

    AdderTreePipelined #(
        .DATA_WIDTH (DATA_WIDTH),
        .LENGTH     (LENGTH)
    ) u_tree (
        .clk        (clk),
        .reset      (reset),
        .in_advance (advance),
        .in_addends (tree_in),
        .out_sum    (tree_sum)
    );

    // Tags travel alongside the tree data and freeze with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr        <= 1'b0;
            tag_valid <= '0;
            tag_id    <= '0;
        end else if (advance) begin
            if (accept && both_valid) begin
                rr <= ~grant_id;
            end
            tag_valid <= (tag_valid << 1) | LATENCY'(accept);
            tag_id    <= (tag_id << 1) | LATENCY'(grant_id);
        end
    end

`ifdef ADDER_TREE_ARB_SKID_EN
    logic                        advance_q;
    logic [1:0]                  fifo_count;
    logic [1:0]                  count_next;
    logic                        rd_ptr;
    logic                        wr_ptr;
    logic                        push;
    logic                        pop;
    logic signed [OUT_WIDTH-1:0] fifo_sum [2];
    logic [1:0]                  fifo_id;

    assign push       = advance & tag_valid[LATENCY-1];
    assign pop        = out_valid & out_ready;
    assign count_next = fifo_count + 2'(push) - 2'(pop);
    // advance_q always equals (fifo_count < 2), so a push never overflows.
    assign advance    = advance_q & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            advance_q   <= 1'b1;
            fifo_count  <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_sum[0] <= '0;
            fifo_sum[1] <= '0;
            fifo_id     <= '0;
        end else begin
            fifo_count <= count_next;
            advance_q  <= (count_next < 2'd2);
            if (push) begin
                fifo_sum[wr_ptr] <= tree_sum;
                fifo_id[wr_ptr]  <= tag_id[LATENCY-1];
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign out_valid = (fifo_count != 2'd0);
    assign out_sum   = fifo_sum[rd_ptr];
    assign out_id    = fifo_id[rd_ptr];
`else
    // A stalled result blocks the whole pipe, including new accepts.
    assign advance   = ~reset & ~(out_valid & ~out_ready);
    assign out_valid = tag_valid[LATENCY-1];
    assign out_id    = tag_id[LATENCY-1];
    assign out_sum   = tree_sum;
`endif
endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Directed bench for adder_tree_arbiter (default build, no output FIFO).
// Drives stimulus one step after each rising edge and checks after settling.

module tb_adder_tree_arbiter;
    localparam int DW  = 5;
    localparam int LEN = 9;
    localparam int OW  = DW + $clog2(LEN);

    typedef logic [LEN-1:0][DW-1:0] vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in0_valid;
    logic            in0_ready;
    vec_t            in0_addends;
    logic            in1_valid;
    logic            in1_ready;
    vec_t            in1_addends;
    logic            out_valid;
    logic            out_ready;
    logic signed [OW-1:0] out_sum;
    logic            out_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rq_sum [$];
    int rq_id  [$];
    int rq_cyc [$];

    adder_tree_arbiter #(
        .DATA_WIDTH (DW),
        .LENGTH     (LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in0_valid   (in0_valid),
        .in0_ready   (in0_ready),
        .in0_addends (in0_addends),
        .in1_valid   (in1_valid),
        .in1_ready   (in1_ready),
        .in1_addends (in1_addends),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_id      (out_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) begin
            rq_sum.push_back(int'(out_sum));
            rq_id.push_back(int'(out_id));
            rq_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t fill(input int v);
        vec_t r;
        for (int i = 0; i < LEN; i++) r[i] = DW'(v);
        return r;
    endfunction

    function automatic int q_sum(input int i);
        return (i < rq_sum.size()) ? rq_sum[i] : -9999;
    endfunction

    function automatic int q_id(input int i);
        return (i < rq_id.size()) ? rq_id[i] : -9999;
    endfunction

    function automatic int q_cyc(input int i);
        return (i < rq_cyc.size()) ? rq_cyc[i] : -9999;
    endfunction

    task automatic clear_q();
        rq_sum.delete();
        rq_id.delete();
        rq_cyc.delete();
    endtask

    initial begin
        int   va [LEN] = '{1, -2, 3, -4, 5, -6, 7, -8, 9};
        vec_t v;
        int   k;
        logic acc;

        // Reset state, with both requesters already offering
        reset       = 1'b1;
        in0_valid   = 1'b1;
        in1_valid   = 1'b1;
        in0_addends = '0;
        in1_addends = '0;
        out_ready   = 1'b1;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in0_ready", in0_ready, 0);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_out_id", out_id, 0);

        // Single vector from req0: sum 5 after 4 edges incl. the accept
        for (int i = 0; i < LEN; i++) v[i] = DW'(va[i]);
        in0_addends = v;
        in1_valid   = 1'b0;
        reset       = 1'b0;
        #1;
        chk("a_first_ready", in0_ready, 1);
        tick();
        in0_valid = 1'b0;
        #1;
        chk("a_lat_e1", out_valid, 0);
        tick();
        chk("a_lat_e2", out_valid, 0);
        tick();
        chk("a_lat_e3", out_valid, 0);
        tick();
        chk("a_lat_e4_valid", out_valid, 1);
        chk("a_sum", $signed(out_sum), 5);
        chk("a_id", out_id, 0);
        tick();
        chk("a_bubble", out_valid, 0);

        // Contention: alternating grants starting with req0
        clear_q();
        in0_addends = fill(1);
        in1_addends = fill(-1);
        in0_valid   = 1'b1;
        in1_valid   = 1'b1;
        #1;
        chk("b_in0_ready", in0_ready, 1);
        chk("b_in1_ready", in1_ready, 0);
        repeat (6) tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        repeat (6) tick();
        chk("b_count", rq_sum.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("b_sum", q_sum(i), (i % 2 == 0) ? 9 : -9);
            chk("b_id", q_id(i), i % 2);
            if (i > 0) chk("b_cycle", q_cyc(i) - q_cyc(i - 1), 1);
        end

        // Extreme addends
        clear_q();
        in0_addends = fill(-16);
        in0_valid   = 1'b1;
        #1;
        tick();
        in0_addends = fill(15);
        tick();
        in0_valid = 1'b0;
        repeat (6) tick();
        chk("c_count", rq_sum.size(), 2);
        chk("c_min_sum", q_sum(0), -144);
        chk("c_max_sum", q_sum(1), 135);
        chk("c_id", q_id(1), 0);

        // Req1 stream of 6 with a 5-cycle output stall
        clear_q();
        k         = 1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            in1_addends = fill(k);
            #1;
            acc = in1_ready;
            tick();
            if (acc) k++;
        end
        chk("d_pre_stall", k, 6);
        in1_addends = fill(6);
        out_ready   = 1'b0;
        #1;
        repeat (5) begin
            chk("d_stall_ready", in1_ready, 0);
            chk("d_stall_valid", out_valid, 1);
            chk("d_stall_sum", $signed(out_sum), 18);
            chk("d_stall_id", out_id, 1);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 12 && k <= 6; c++) begin
            in1_addends = fill(k);
            #1;
            acc = in1_ready;
            tick();
            if (acc) k++;
        end
        chk("d_all_accepted", k, 7);
        in1_valid = 1'b0;
        repeat (8) tick();
        chk("d_count", rq_sum.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("d_sum", q_sum(i), 9 * (i + 1));
            chk("d_id", q_id(i), 1);
        end

        // Reset with vectors in flight
        in0_addends = fill(2);
        in1_addends = fill(3);
        in0_valid   = 1'b1;
        in1_valid   = 1'b1;
        #1;
        tick();
        in0_valid = 1'b0;
        repeat (3) tick();
        chk("e_pre_valid", out_valid, 1);
        chk("e_pre_sum", $signed(out_sum), 18);
        clear_q();
        reset = 1'b1;
        #1;
        chk("e_async_valid", out_valid, 0);
        chk("e_async_id", out_id, 0);
        chk("e_async_ready", in1_ready, 0);
        tick();
        reset       = 1'b0;
        in0_valid   = 1'b1;
        in1_valid   = 1'b1;
        in1_addends = fill(-1);
        #1;
        chk("e_rr_in0", in0_ready, 1);
        chk("e_rr_in1", in1_ready, 0);
        in0_valid = 1'b0;
        #1;
        chk("e_in1_wins", in1_ready, 1);
        tick();
        in1_valid = 1'b0;
        repeat (6) tick();
        chk("e_count", rq_sum.size(), 1);
        chk("e_sum", q_sum(0), -9);
        chk("e_id", q_id(0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
